// File: rtl/fsm_guard_pkg.sv
// Shared types and helpers for the fsm_visit_guard runtime monitor.
package fsm_guard_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    TRIP  = 2'd2
  } state_t;

  // $clog2 that never returns 0, so a single-channel build still gets a 1-bit index
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 32'd1) ? 32'd1 : 32'($clog2(n));
  endfunction

  // LSB position of field idx in a packed array of width-wide fields
  function automatic int unsigned slice_lsb(input int unsigned idx, input int unsigned width);
    return idx * width;
  endfunction

endpackage

// File: rtl/fsm_guard_ch.sv
// One watch channel: entry detector, saturating visit counter, threshold alarm, mismatch flag.
module fsm_guard_ch
  import fsm_guard_pkg::*;
#(
  parameter int unsigned STATE_W = 5,
  parameter int unsigned OUT_W   = 23,
  parameter int unsigned CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               active,
  input  logic               armed,
  input  logic               prev_valid,
  input  logic [STATE_W-1:0] st,
  input  logic [STATE_W-1:0] prev_st,
  input  logic [STATE_W-1:0] watch_st,
  input  logic [CNT_W-1:0]   thr,
  input  logic [OUT_W-1:0]   y,
  input  logic [OUT_W-1:0]   exp_y,
  input  logic [OUT_W-1:0]   care_y,
  output logic               hit_c,
  output logic               mis_c,
  output logic [CNT_W-1:0]   cnt,
  output logic               thr_alarm
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             match;
  logic [CNT_W-1:0] cnt_inc;

  // A self-loop counts once: only the entry cycle is a hit
  always_comb begin
    match   = (st == watch_st);
    hit_c   = active && match && (!prev_valid || (prev_st != watch_st));
    mis_c   = armed && match && (|((y ^ exp_y) & care_y));
    cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      thr_alarm <= 1'b0;
    end else if (clr) begin
      cnt       <= '0;
      thr_alarm <= 1'b0;
    end else if (hit_c) begin
      cnt <= cnt_inc;
      if ((thr != '0) && (cnt_inc >= thr)) begin
        thr_alarm <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/fsm_visit_guard.sv
// Runtime monitor for a host Mealy FSM: per-state visit counts, threshold and golden-output alarms.
module fsm_visit_guard
  import fsm_guard_pkg::*;
#(
  parameter int unsigned STATE_W = 5,
  parameter int unsigned OUT_W   = 23,
  parameter int unsigned N_CH    = 4,
  parameter int unsigned CNT_W   = 8,
  localparam int unsigned CH_W   = clog2_min1(N_CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     clr,
  input  logic [STATE_W-1:0]       st,
  input  logic [OUT_W-1:0]         y,
  input  logic [N_CH*STATE_W-1:0]  watch_st,
  input  logic [N_CH*CNT_W-1:0]    thr,
  input  logic [N_CH*OUT_W-1:0]    exp_y,
  input  logic [N_CH*OUT_W-1:0]    care_y,
  output logic [N_CH*CNT_W-1:0]    cnt,
  output logic [N_CH-1:0]          thr_alarm,
  output logic                     mis_alarm,
  output logic [CH_W-1:0]          mis_ch,
  output logic [OUT_W-1:0]         mis_y,
  output logic                     busy
);

  state_t             state, state_nxt;
  logic               active, armed;
  logic [STATE_W-1:0] prev_st;
  logic               prev_valid;
  logic [N_CH-1:0]    hit_c, mis_c;
  logic               any_mis;
  logic [CH_W-1:0]    first_ch;

  assign armed  = (state == ARMED);
  assign active = (state == ARMED) || (state == TRIP);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    fsm_guard_ch #(
      .STATE_W (STATE_W),
      .OUT_W   (OUT_W),
      .CNT_W   (CNT_W)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .clr        (clr),
      .active     (active),
      .armed      (armed),
      .prev_valid (prev_valid),
      .st         (st),
      .prev_st    (prev_st),
      .watch_st   (watch_st[slice_lsb(i, STATE_W) +: STATE_W]),
      .thr        (thr[slice_lsb(i, CNT_W) +: CNT_W]),
      .y          (y),
      .exp_y      (exp_y[slice_lsb(i, OUT_W) +: OUT_W]),
      .care_y     (care_y[slice_lsb(i, OUT_W) +: OUT_W]),
      .hit_c      (hit_c[i]),
      .mis_c      (mis_c[i]),
      .cnt        (cnt[slice_lsb(i, CNT_W) +: CNT_W]),
      .thr_alarm  (thr_alarm[i])
    );
  end

  // Lowest mismatching channel index wins
  always_comb begin
    any_mis  = 1'b0;
    first_ch = '0;
    for (int i = int'(N_CH) - 1; i >= 0; i--) begin
      if (mis_c[i]) begin
        any_mis  = 1'b1;
        first_ch = CH_W'(i);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (!clr && en) state_nxt = ARMED;
      end
      ARMED: begin
        if (clr)          state_nxt = IDLE;
        else if (any_mis) state_nxt = TRIP;
        else if (!en)     state_nxt = IDLE;
      end
      TRIP: begin
        if (clr) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt == ARMED);
    end
  end

  // Previous-state tracker; all-ones/invalid makes the first monitored cycle an entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_st    <= '1;
      prev_valid <= 1'b0;
    end else if (clr) begin
      prev_st    <= '1;
      prev_valid <= 1'b0;
    end else begin
      prev_st    <= st;
      prev_valid <= active;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mis_alarm <= 1'b0;
      mis_ch    <= '0;
      mis_y     <= '0;
    end else if (clr) begin
      mis_alarm <= 1'b0;
      mis_ch    <= '0;
      mis_y     <= '0;
    end else if (any_mis && !mis_alarm) begin
      mis_alarm <= 1'b1;
      mis_ch    <= first_ch;
      mis_y     <= y;
    end
  end

endmodule

// File: tb/tb_fsm_visit_guard.sv
// Directed bench for fsm_visit_guard: default build plus a CNT_W=4 single-channel build for saturation.
module tb_fsm_visit_guard;

  logic        clk, rst, en, clr;
  logic [4:0]  st;
  logic [22:0] y;
  logic [19:0] watch_st;
  logic [31:0] thr;
  logic [91:0] exp_y, care_y;
  logic [31:0] cnt;
  logic [3:0]  thr_alarm;
  logic        mis_alarm;
  logic [1:0]  mis_ch;
  logic [22:0] mis_y;
  logic        busy;

  logic [4:0]  s_watch;
  logic [3:0]  s_thr;
  logic [22:0] s_exp, s_care;
  logic [3:0]  s_cnt;
  logic [0:0]  s_thr_alarm;
  logic        s_mis_alarm;
  logic [0:0]  s_mis_ch;
  logic [22:0] s_mis_y;
  logic        s_busy;

  int n_chk  = 0;
  int n_pass = 0;

  fsm_visit_guard u_dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .st(st), .y(y),
    .watch_st(watch_st), .thr(thr), .exp_y(exp_y), .care_y(care_y),
    .cnt(cnt), .thr_alarm(thr_alarm), .mis_alarm(mis_alarm),
    .mis_ch(mis_ch), .mis_y(mis_y), .busy(busy)
  );

  fsm_visit_guard #(.N_CH(1), .CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .st(st), .y(y),
    .watch_st(s_watch), .thr(s_thr), .exp_y(s_exp), .care_y(s_care),
    .cnt(s_cnt), .thr_alarm(s_thr_alarm), .mis_alarm(s_mis_alarm),
    .mis_ch(s_mis_ch), .mis_y(s_mis_y), .busy(s_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp_v);
    n_chk++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp_v);
  endtask

  // Hold st for one clock, then settle just after the edge
  task automatic cyc(input logic [4:0] s);
    st = s;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; clr = 1'b0; st = 5'd0; y = '0;
    watch_st = {5'd19, 5'd10, 5'd19, 5'd5};
    thr      = {8'd0, 8'd0, 8'd3, 8'd3};
    exp_y    = '0;
    care_y   = '0;
    s_watch = 5'd7; s_thr = 4'd15; s_exp = '0; s_care = '0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_cnt",   64'(cnt), 64'd0);
    check("rst_thr",   64'(thr_alarm), 64'd0);
    check("rst_mis",   64'(mis_alarm), 64'd0);
    check("rst_busy",  64'(busy), 64'd0);
    rst = 1'b0;

    // entry counting on ch0
    en = 1'b1;
    cyc(5'd0);
    check("busy_on", 64'(busy), 64'd1);
    cyc(5'd4); cyc(5'd5); cyc(5'd5); cyc(5'd5); cyc(5'd6); cyc(5'd5);
    check("cnt0_entries", 64'(cnt[7:0]), 64'd2);
    check("thr0_below",   64'(thr_alarm[0]), 64'd0);

    // threshold on ch1, independent twin ch3
    cyc(5'd19); cyc(5'd0); cyc(5'd19); cyc(5'd0);
    check("cnt1_two",   64'(cnt[15:8]), 64'd2);
    check("thr1_early", 64'(thr_alarm[1]), 64'd0);
    cyc(5'd19);
    check("cnt1_three", 64'(cnt[15:8]), 64'd3);
    check("thr1_set",   64'(thr_alarm[1]), 64'd1);
    check("cnt3_twin",  64'(cnt[31:24]), 64'd3);
    check("thr3_off",   64'(thr_alarm[3]), 64'd0);
    for (int i = 0; i < 10; i++) begin
      cyc(5'd10); cyc(5'd0);
    end
    check("cnt2_ten",  64'(cnt[23:16]), 64'd10);
    check("thr2_zero", 64'(thr_alarm[2]), 64'd0);

    // drop en: counters hold in IDLE
    en = 1'b0;
    cyc(5'd0);
    check("busy_off", 64'(busy), 64'd0);
    cyc(5'd5); cyc(5'd0); cyc(5'd5);
    check("cnt0_hold", 64'(cnt[7:0]), 64'd2);

    // clr coincident with an entry
    en = 1'b1;
    cyc(5'd0); cyc(5'd0);
    clr = 1'b1;
    cyc(5'd5);
    clr = 1'b0;
    check("clr_cnt",  64'(cnt), 64'd0);
    check("clr_thr",  64'(thr_alarm), 64'd0);
    check("clr_busy", 64'(busy), 64'd0);
    cyc(5'd5); cyc(5'd5);
    check("rearm_cnt0", 64'(cnt[7:0]), 64'd1);
    check("rearm_busy", 64'(busy), 64'd1);

    // mismatch priority: ch1 and ch3 both watch 19
    exp_y[45:23]  = '1; care_y[45:23] = '1;
    exp_y[91:69]  = '1; care_y[91:69] = '1;
    y = 23'd0;
    cyc(5'd19);
    check("mis_alarm", 64'(mis_alarm), 64'd1);
    check("mis_ch",    64'(mis_ch), 64'd1);
    check("mis_y",     64'(mis_y), 64'd0);
    check("trip_busy", 64'(busy), 64'd0);
    check("mis_cnt3",  64'(cnt[31:24]), 64'd1);
    y = 23'd1;
    cyc(5'd0); cyc(5'd19);
    check("mis_y_keep",  64'(mis_y), 64'd0);
    check("mis_ch_keep", 64'(mis_ch), 64'd1);
    check("trip_count",  64'(cnt[15:8]), 64'd2);

    // async reset between edges
    #2;
    rst = 1'b1;
    #1;
    check("arst_mis",  64'(mis_alarm), 64'd0);
    check("arst_ch",   64'(mis_ch), 64'd0);
    check("arst_cnt",  64'(cnt), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // saturation on the 4-bit build
    en = 1'b1;
    cyc(5'd0);
    for (int i = 0; i < 14; i++) begin
      cyc(5'd7); cyc(5'd0);
    end
    check("sat_cnt14", 64'(s_cnt), 64'd14);
    check("sat_thr14", 64'(s_thr_alarm), 64'd0);
    cyc(5'd7);
    check("sat_cnt15", 64'(s_cnt), 64'd15);
    check("sat_thr15", 64'(s_thr_alarm), 64'd1);
    for (int i = 0; i < 5; i++) begin
      cyc(5'd0); cyc(5'd7);
    end
    check("sat_hold",     64'(s_cnt), 64'd15);
    check("sat_thr_hold", 64'(s_thr_alarm), 64'd1);
    check("sat_main_cnt", 64'(cnt), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
